// File: rtl/de_pipe_reg.sv
// de_pipe_reg: Decode-to-Execute pipeline register of the 5-stage MIPS core.
// Captures decoded fields and operands and resolves late M/W results at capture time.
// Also inserts bubbles on stall, clears on flush, ages Tnew, counts bubbles and
// keeps a sticky hazard-error flag.
module de_pipe_reg #(
    parameter int PAY_W = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [PAY_W-1:0] d_payload,
    input  logic [4:0]       d_rs_addr,
    input  logic [4:0]       d_rt_addr,
    input  logic [31:0]      d_rs_val,
    input  logic [31:0]      d_rt_val,
    input  logic [4:0]       d_tar,
    input  logic             d_we,
    input  logic [1:0]       d_tnew,
    input  logic             stall,
    input  logic             flush,
    input  logic [4:0]       m_tar,
    input  logic             m_we,
    input  logic [31:0]      m_wd,
    input  logic             m_wd_ok,
    input  logic [4:0]       w_tar,
    input  logic             w_we,
    input  logic [31:0]      w_wd,
    output logic             e_valid,
    output logic [PAY_W-1:0] e_payload,
    output logic [4:0]       e_rs_addr,
    output logic [4:0]       e_rt_addr,
    output logic [31:0]      e_rs_val,
    output logic [31:0]      e_rt_val,
    output logic [4:0]       e_tar,
    output logic             e_we,
    output logic [1:0]       e_tnew,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic             hazard_err
);

    // Tnew counts down by one stage per hop and never goes below zero.
    function automatic logic [1:0] age_tnew(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Operand selection: $0 is hardwired, M beats W, otherwise register file.
    function automatic logic [31:0] fwd_operand(
        input logic [4:0]  a,
        input logic [31:0] rf,
        input logic        mwe,
        input logic [4:0]  mtar,
        input logic [31:0] mwd,
        input logic        wwe,
        input logic [4:0]  wtar,
        input logic [31:0] wwd
    );
        if (a == 5'd0)
            return 32'd0;
        else if (mwe && (mtar == a))
            return mwd;
        else if (wwe && (wtar == a))
            return wwd;
        else
            return rf;
    endfunction

    // True when the operand must come from M but M has not produced it yet.
    function automatic logic late_m(
        input logic [4:0] a,
        input logic       mwe,
        input logic [4:0] mtar,
        input logic       mok
    );
        return (a != 5'd0) && mwe && (mtar == a) && !mok;
    endfunction

    logic [31:0]      rs_val_p0;
    logic [31:0]      rt_val_p0;
    logic             haz_p0;

    logic             vld_p1;
    logic [PAY_W-1:0] payload_p1;
    logic [4:0]       rs_addr_p1;
    logic [4:0]       rt_addr_p1;
    logic [31:0]      rs_val_p1;
    logic [31:0]      rt_val_p1;
    logic [4:0]       tar_p1;
    logic             we_p1;
    logic [1:0]       tnew_p1;
    logic [CNT_W-1:0] cnt_p1;
    logic             haz_p1;

    // D side: forwarded operand values and late-M detection, only for real instructions.
    always_comb begin
        rs_val_p0 = 32'd0;
        rt_val_p0 = 32'd0;
        haz_p0    = 1'b0;
        if (d_valid) begin
            rs_val_p0 = fwd_operand(d_rs_addr, d_rs_val, m_we, m_tar, m_wd, w_we, w_tar, w_wd);
            rt_val_p0 = fwd_operand(d_rt_addr, d_rt_val, m_we, m_tar, m_wd, w_we, w_tar, w_wd);
            haz_p0    = late_m(d_rs_addr, m_we, m_tar, m_wd_ok)
                      | late_m(d_rt_addr, m_we, m_tar, m_wd_ok);
        end
    end

    // D -> E register: flush or stall inject a bubble, otherwise load D.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_p1     <= 1'b0;
            payload_p1 <= '0;
            rs_addr_p1 <= '0;
            rt_addr_p1 <= '0;
            rs_val_p1  <= '0;
            rt_val_p1  <= '0;
            tar_p1     <= '0;
            we_p1      <= 1'b0;
            tnew_p1    <= '0;
        end else if (flush || stall) begin
            vld_p1     <= 1'b0;
            payload_p1 <= '0;
            rs_addr_p1 <= '0;
            rt_addr_p1 <= '0;
            rs_val_p1  <= '0;
            rt_val_p1  <= '0;
            tar_p1     <= '0;
            we_p1      <= 1'b0;
            tnew_p1    <= '0;
        end else begin
            vld_p1     <= d_valid;
            payload_p1 <= d_payload;
            rs_addr_p1 <= d_rs_addr;
            rt_addr_p1 <= d_rt_addr;
            rs_val_p1  <= rs_val_p0;
            rt_val_p1  <= rt_val_p0;
            tar_p1     <= d_tar;
            we_p1      <= d_we;
            tnew_p1    <= age_tnew(d_tnew);
        end
    end

    // Bubble counter: one count per stalled edge; a flush bubble is not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_p1 <= '0;
        else if (stall && !flush)
            cnt_p1 <= cnt_p1 + CNT_W'(1);
    end

    // Sticky hazard flag: set when a loaded operand needed M data that was not ready.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            haz_p1 <= 1'b0;
        else if (!flush && !stall && haz_p0)
            haz_p1 <= 1'b1;
    end

    assign e_valid    = vld_p1;
    assign e_payload  = payload_p1;
    assign e_rs_addr  = rs_addr_p1;
    assign e_rt_addr  = rt_addr_p1;
    assign e_rs_val   = rs_val_p1;
    assign e_rt_val   = rt_val_p1;
    assign e_tar      = tar_p1;
    assign e_we       = we_p1;
    assign e_tnew     = tnew_p1;
    assign bubble_cnt = cnt_p1;
    assign hazard_err = haz_p1;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Testbench for de_pipe_reg: directed steps plus randomized loads against a reference model.
module tb_de_pipe_reg;

    localparam int PAY_W = 64;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             d_valid;
    logic [PAY_W-1:0] d_payload;
    logic [4:0]       d_rs_addr, d_rt_addr, d_tar, m_tar, w_tar;
    logic [31:0]      d_rs_val, d_rt_val, m_wd, w_wd;
    logic             d_we, stall, flush, m_we, m_wd_ok, w_we;
    logic [1:0]       d_tnew;
    logic             e_valid;
    logic [PAY_W-1:0] e_payload;
    logic [4:0]       e_rs_addr, e_rt_addr, e_tar;
    logic [31:0]      e_rs_val, e_rt_val;
    logic             e_we;
    logic [1:0]       e_tnew;
    logic [CNT_W-1:0] bubble_cnt;
    logic             hazard_err;

    de_pipe_reg #(.PAY_W(PAY_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .d_valid(d_valid), .d_payload(d_payload),
        .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
        .d_rs_val(d_rs_val), .d_rt_val(d_rt_val),
        .d_tar(d_tar), .d_we(d_we), .d_tnew(d_tnew),
        .stall(stall), .flush(flush),
        .m_tar(m_tar), .m_we(m_we), .m_wd(m_wd), .m_wd_ok(m_wd_ok),
        .w_tar(w_tar), .w_we(w_we), .w_wd(w_wd),
        .e_valid(e_valid), .e_payload(e_payload),
        .e_rs_addr(e_rs_addr), .e_rt_addr(e_rt_addr),
        .e_rs_val(e_rs_val), .e_rt_val(e_rt_val),
        .e_tar(e_tar), .e_we(e_we), .e_tnew(e_tnew),
        .bubble_cnt(bubble_cnt), .hazard_err(hazard_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model state: what E should hold.
    logic             x_valid;
    logic [PAY_W-1:0] x_payload;
    int               x_rs_addr, x_rt_addr, x_tar, x_tnew, x_cnt;
    longint           x_rs_val, x_rt_val;
    logic             x_we, x_haz;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    function automatic void model_clear_e();
        x_valid = 0; x_payload = '0; x_rs_addr = 0; x_rt_addr = 0;
        x_rs_val = 0; x_rt_val = 0; x_tar = 0; x_we = 0; x_tnew = 0;
    endfunction

    function automatic void model_reset();
        model_clear_e();
        x_cnt = 0;
        x_haz = 0;
    endfunction

    // Value E should see for one operand, from the forwarding rules.
    function automatic longint operand(input int a, input longint rf);
        if (a == 0)                    return 0;
        if (m_we && int'(m_tar) == a)  return longint'(m_wd);
        if (w_we && int'(w_tar) == a)  return longint'(w_wd);
        return rf;
    endfunction

    function automatic bit needs_unready_m(input int a);
        return a != 0 && m_we && int'(m_tar) == a && !m_wd_ok;
    endfunction

    // Advance the model by one rising edge using the inputs currently applied.
    function automatic void model_edge();
        if (!reset) begin
            model_reset();
        end else if (flush) begin
            model_clear_e();
        end else if (stall) begin
            model_clear_e();
            x_cnt = (x_cnt + 1) % (1 << CNT_W);
        end else begin
            x_valid   = d_valid;
            x_payload = d_payload;
            x_rs_addr = d_rs_addr;
            x_rt_addr = d_rt_addr;
            x_tar     = d_tar;
            x_we      = d_we;
            x_tnew    = (int'(d_tnew) > 0) ? int'(d_tnew) - 1 : 0;
            if (d_valid) begin
                x_rs_val = operand(d_rs_addr, longint'(d_rs_val));
                x_rt_val = operand(d_rt_addr, longint'(d_rt_val));
                if (needs_unready_m(d_rs_addr) || needs_unready_m(d_rt_addr)) x_haz = 1;
            end else begin
                x_rs_val = 0;
                x_rt_val = 0;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"},   64'(e_valid),    64'(x_valid));
        chk({tag, ".payload"}, 64'(e_payload),  64'(x_payload));
        chk({tag, ".rs_addr"}, 64'(e_rs_addr),  64'(x_rs_addr));
        chk({tag, ".rt_addr"}, 64'(e_rt_addr),  64'(x_rt_addr));
        chk({tag, ".rs_val"},  64'(e_rs_val),   64'(x_rs_val));
        chk({tag, ".rt_val"},  64'(e_rt_val),   64'(x_rt_val));
        chk({tag, ".tar"},     64'(e_tar),      64'(x_tar));
        chk({tag, ".we"},      64'(e_we),       64'(x_we));
        chk({tag, ".tnew"},    64'(e_tnew),     64'(x_tnew));
        chk({tag, ".cnt"},     64'(bubble_cnt), 64'(x_cnt));
        chk({tag, ".haz"},     64'(hazard_err), 64'(x_haz));
    endtask

    // One clock edge: model follows, outputs sampled 1 time unit later.
    task automatic step(input string tag, input bit do_check);
        @(posedge clk);
        model_edge();
        #1;
        if (do_check) check_all(tag);
    endtask

    task automatic idle_inputs();
        d_valid = 0; d_payload = '0; d_rs_addr = 0; d_rt_addr = 0;
        d_rs_val = 0; d_rt_val = 0; d_tar = 0; d_we = 0; d_tnew = 0;
        stall = 0; flush = 0; m_tar = 0; m_we = 0; m_wd = 0; m_wd_ok = 1;
        w_tar = 0; w_we = 0; w_wd = 0;
    endtask

    task automatic rand_inputs();
        d_valid   = ($urandom_range(0, 3) != 0);
        d_payload = {$urandom, $urandom};
        d_rs_addr = 5'($urandom_range(0, 3));
        d_rt_addr = 5'($urandom_range(0, 3));
        d_rs_val  = $urandom;
        d_rt_val  = $urandom;
        d_tar     = 5'($urandom);
        d_we      = 1'($urandom);
        d_tnew    = 2'($urandom);
        stall     = ($urandom_range(0, 5) == 0);
        flush     = ($urandom_range(0, 9) == 0);
        m_tar     = 5'($urandom_range(0, 3));
        m_we      = 1'($urandom);
        m_wd      = $urandom;
        m_wd_ok   = ($urandom_range(0, 15) != 0);
        w_tar     = 5'($urandom_range(0, 3));
        w_we      = 1'($urandom);
        w_wd      = $urandom;
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        model_reset();

        // Reset state
        #2;
        check_all("reset_async");
        step("reset_hold", 1'b1);
        reset = 1;

        // Basic load, no forwarding
        d_valid = 1; d_payload = 64'hDEAD_BEEF_0123_4567;
        d_rs_addr = 1; d_rt_addr = 2; d_rs_val = 32'h11; d_rt_val = 32'h22;
        d_tar = 7; d_we = 1; d_tnew = 2;
        step("basic", 1'b1);
        chk("basic.rs_const", 64'(e_rs_val), 64'h11);
        chk("basic.rt_const", 64'(e_rt_val), 64'h22);
        chk("basic.tnew_const", 64'(e_tnew), 64'd1);
        chk("basic.valid_const", 64'(e_valid), 64'd1);

        // M beats W, then W alone
        d_rs_addr = 5; m_we = 1; m_tar = 5; m_wd = 32'hAAAA; m_wd_ok = 1;
        w_we = 1; w_tar = 5; w_wd = 32'hBBBB;
        step("fwd_m", 1'b1);
        chk("fwd_m.const", 64'(e_rs_val), 64'hAAAA);
        chk("fwd_m.haz_const", 64'(hazard_err), 64'd0);
        m_we = 0;
        step("fwd_w", 1'b1);
        chk("fwd_w.const", 64'(e_rs_val), 64'hBBBB);

        // $0 is never forwarded; Tnew saturates at 0
        d_rt_addr = 0; d_rt_val = 32'h5555; m_we = 1; m_tar = 0; m_wd = 32'h1234;
        w_we = 1; w_tar = 0; d_tnew = 0;
        step("zero_reg", 1'b1);
        chk("zero_reg.const", 64'(e_rt_val), 64'd0);

        // Invalid D: values captured as zero, matching unready M is not a hazard
        d_valid = 0; d_rs_addr = 3; m_tar = 3; m_wd_ok = 0; d_tnew = 3;
        step("invalid", 1'b1);
        m_wd_ok = 1; w_we = 0; m_we = 0;

        // Stall three cycles, then flush with stall
        d_valid = 1; stall = 1;
        step("stall1", 1'b1);
        step("stall2", 1'b1);
        step("stall3", 1'b1);
        flush = 1;
        step("flush", 1'b1);
        chk("flush.cnt_const", 64'(bubble_cnt), 64'd3);
        stall = 0; flush = 0;

        // Unready M match sets sticky hazard
        d_rs_addr = 9; m_we = 1; m_tar = 9; m_wd = 32'hCAFE; m_wd_ok = 0;
        step("hazard", 1'b1);
        chk("hazard.const", 64'(hazard_err), 64'd1);
        m_we = 0; m_wd_ok = 1;
        for (int i = 0; i < 10; i++) begin
            d_rs_val = $urandom;
            step("clean", 1'b1);
        end
        chk("sticky.const", 64'(hazard_err), 64'd1);

        // Asynchronous reset between edges while E is valid
        d_valid = 1; d_tnew = 2;
        step("pre_areset", 1'b1);
        #2;
        reset = 0;
        model_reset();
        #1;
        check_all("areset");
        chk("areset.haz_const", 64'(hazard_err), 64'd0);
        step("areset_hold", 1'b1);
        reset = 1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            step("rand", 1'b1);
        end

        // Bubble counter wrap
        idle_inputs();
        stall = 1;
        while (x_cnt != (1 << CNT_W) - 1) step("wrap_run", 1'b0);
        check_all("wrap_max");
        step("wrap", 1'b1);
        chk("wrap.const", 64'(bubble_cnt), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/de_pipe_reg.md
Name: de_pipe_reg

Overview:
- Pipeline register between the Decode stage (register-file read) and the Execute stage of the 5-stage MIPS core.
- Captures the decoded message fields and the RS/RT operand values read in D.
- Resolves late operand updates from M/W by forwarding at capture time.
- Inserts bubbles on stall, clears on flush, ages the Tnew field, and keeps a bubble counter and a sticky hazard-error flag.

Parameters:
- PAY_W, 64: width of opaque pass-through payload (instr, pc, control bits).
- CNT_W, 16: width of bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- d_valid  in  1  D stage holds a real instruction.
- d_payload  in  PAY_W  pass-through payload.
- d_rs_addr  in  5  rs index.
- d_rt_addr  in  5  rt index.
- d_rs_val  in  32  RD1 from register file.
- d_rt_val  in  32  RD2 from register file.
- d_tar  in  5  destination register.
- d_we  in  1  instruction writes GRF.
- d_tnew  in  2  cycles until result ready, counted from D.
- stall  in  1  hazard unit: hold D, bubble into E.
- flush  in  1  clear E (exception/redirect).
- m_tar  in  5  M-stage destination register.
- m_we  in  1  M-stage write enable.
- m_wd  in  32  M-stage result.
- m_wd_ok  in  1  M-stage result is ready (Tnew==0 in M).
- w_tar  in  5  W-stage destination register.
- w_we  in  1  W-stage write enable.
- w_wd  in  32  W-stage write data.
- e_valid  out  1  E holds a real instruction.
- e_payload  out  PAY_W  registered payload.
- e_rs_addr  out  5  registered rs index.
- e_rt_addr  out  5  registered rt index.
- e_rs_val  out  32  registered, forwarded rs value.
- e_rt_val  out  32  registered, forwarded rt value.
- e_tar  out  5  registered destination register.
- e_we  out  1  registered write enable.
- e_tnew  out  2  aged Tnew.
- bubble_cnt  out  CNT_W  bubbles inserted since reset.
- hazard_err  out  1  sticky: forwarding needed but M data was not ready.

Behaviour:
- Reset (reset=0, asynchronous): every output is 0, including bubble_cnt and hazard_err. On deassertion, normal operation starts at the next rising edge.
- Update priority at each rising edge: flush > stall > load.
- flush=1:
  - All e_* outputs are cleared to 0 (bubble).
  - bubble_cnt is not incremented.
  - hazard_err is unchanged.
- stall=1 and flush=0:
  - E is loaded with a bubble (all e_* = 0).
  - bubble_cnt increments by 1, wrapping from all-ones to 0.
- Load (stall=0, flush=0):
  - e_valid <= d_valid.
  - Payload, addr, tar and we are copied.
  - e_tnew <= (d_tnew==0) ? 0 : d_tnew-1, saturating at 0.
- Operand forwarding at load, per operand, for index a = d_rs_addr or d_rt_addr:
  - a==0: value is 0. Register $0 is never forwarded.
  - Else if m_we && m_tar==a: value is m_wd.
    - If also m_wd_ok==0, hazard_err <= 1 (sticky until reset). m_wd is still captured.
  - Else if w_we && w_tar==a: value is w_wd.
  - Else: value is the register-file value.
  - M has priority over W.
- Forwarding, hazard checking and value capture apply only when d_valid=1. When d_valid=0, a load captures zeros in the value fields.
- Latency: one cycle from D inputs to E outputs. No combinational path from inputs to outputs.
- Stall asserted across consecutive cycles: one bubble per cycle, counted each cycle.
- Reset asserted mid-operation clears state immediately, without waiting for clk.

Test Plan:
- Reset, then d_valid=1, d_rs_val=0x11, d_rt_val=0x22, d_tnew=2, no forward match -> next edge e_valid=1, e_rs_val=0x11, e_rt_val=0x22, e_tnew=1.
- d_rs_addr=5, m_we=1, m_tar=5, m_wd=0xAAAA, m_wd_ok=1, w_we=1, w_tar=5, w_wd=0xBBBB -> e_rs_val=0xAAAA, hazard_err=0. Same with m_we=0 -> e_rs_val=0xBBBB.
- d_rt_addr=0, m_we=1, m_tar=0, m_wd=0x1234 -> e_rt_val=0.
- m_tar matches rs with m_wd_ok=0 -> hazard_err=1. It remains 1 after 10 further clean loads and clears only on reset=0.
- stall=1 for 3 cycles, then flush=1 together with stall=1 for 1 cycle -> e_valid=0 throughout, bubble_cnt=3. bubble_cnt wraps from 0xFFFF to 0 on the next stall.
- Assert reset=0 between clock edges while e_valid=1 -> all outputs 0 immediately.
